// File: rtl/if_fetch_stage_if.sv
// Instruction-memory channel between the fetch stage (master) and instruction memory (slave):
// a valid/ready request carrying a word address, and an in-order response that has only a valid.
interface if_fetch_stage_if;
    logic        IMem_req_valid;
    logic        IMem_req_ready;
    logic [31:0] IMem_addr;
    logic        IMem_rsp_valid;
    logic [31:0] IMem_rsp_data;

    modport master (
        output IMem_req_valid,
        output IMem_addr,
        input  IMem_req_ready,
        input  IMem_rsp_valid,
        input  IMem_rsp_data
    );

    modport slave (
        input  IMem_req_valid,
        input  IMem_addr,
        output IMem_req_ready,
        output IMem_rsp_valid,
        output IMem_rsp_data
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight and feeds decode
// through a registered IF_PC/IF_Instruction/IF_Valid, honouring stall and redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IF_Stall,
    input  logic        Redirect_valid,
    input  logic [31:0] Redirect_PC,
    if_fetch_stage_if.master imem,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_Instruction,
    output logic        IF_Valid
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;

    logic req_valid;
    logic req_fire;

    // A new request goes out from FETCH, or from WAIT in the very cycle its predecessor returns
    // and decode can take it, which is what gives one instruction per cycle on 1-cycle memory.
    always_comb begin
        req_valid = !Reset && !Redirect_valid &&
                    ((state_q == ST_FETCH) ||
                     ((state_q == ST_WAIT) && imem.IMem_rsp_valid && !IF_Stall));
        req_fire  = req_valid && imem.IMem_req_ready;
    end

    assign imem.IMem_req_valid = req_valid;
    assign imem.IMem_addr      = pc_q;

    always_comb begin
        // NOTE: every next-state value starts from its hold value so no path infers a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        if_valid_d   = if_valid_q;

        if (!IF_Stall) begin
            if_pc_d    = '0;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end

        if (Redirect_valid) begin
            pc_d         = Redirect_PC & ~32'd3;
            if_pc_d      = '0;
            if_instr_d   = NOP_INSTR;
            if_valid_d   = 1'b0;
            hold_pc_d    = '0;
            hold_instr_d = '0;
            // An outstanding request whose response has not arrived must be drained.
            case (state_q)
                ST_WAIT, ST_DRAIN: state_d = imem.IMem_rsp_valid ? ST_FETCH : ST_DRAIN;
                default:           state_d = ST_FETCH;
            endcase
        end else begin
            if (req_fire) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + 32'd4;
            end

            case (state_q)
                ST_FETCH: begin
                    if (req_fire) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem.IMem_rsp_valid) begin
                        if (IF_Stall) begin
                            hold_pc_d    = req_pc_q;
                            hold_instr_d = imem.IMem_rsp_data;
                            state_d      = ST_HOLD;
                        end else begin
                            if_pc_d    = req_pc_q;
                            if_instr_d = imem.IMem_rsp_data;
                            if_valid_d = 1'b1;
                            state_d    = req_fire ? ST_WAIT : ST_FETCH;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!IF_Stall) begin
                        if_pc_d    = hold_pc_q;
                        if_instr_d = hold_instr_q;
                        if_valid_d = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem.IMem_rsp_valid) state_d = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // NOTE: state registers update with <= so every flop samples the pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC_ALIGNED;
            req_pc_q     <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            if_pc_q      <= '0;
            if_instr_q   <= NOP_INSTR;
            if_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            if_valid_q   <= if_valid_d;
        end
    end

    assign IF_PC          = if_pc_q;
    assign IF_Instruction = if_instr_q;
    assign IF_Valid       = if_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a variable-latency memory, a flag-based behavioural
// model compared every cycle, and directed scenarios with literal expectations.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        IF_Stall;
    logic        Redirect_valid;
    logic [31:0] Redirect_PC;
    logic [31:0] IF_PC;
    logic [31:0] IF_Instruction;
    logic        IF_Valid;

    if_fetch_stage_if imem_bus ();

    if_fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .IF_Stall      (IF_Stall),
        .Redirect_valid(Redirect_valid),
        .Redirect_PC   (Redirect_PC),
        .imem          (imem_bus),
        .IF_PC         (IF_PC),
        .IF_Instruction(IF_Instruction),
        .IF_Valid      (IF_Valid)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // ---------------- memory: one outstanding request, latency chosen at acceptance ----------
    int          mem_lat = 1;
    int          snap_lat = 1;
    logic        snap_hs = 1'b0;
    logic        snap_rsp = 1'b0;
    logic        snap_reset = 1'b1;
    logic [31:0] snap_addr = '0;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    always @(posedge Clk) begin
        #1;
        if (snap_reset) begin
            mem_busy = 1'b0;
        end else begin
            if (snap_rsp) mem_busy = 1'b0;
            if (snap_hs) begin
                mem_busy = 1'b1;
                mem_addr = snap_addr;
                mem_cnt  = snap_lat;
            end
            if (mem_busy && mem_cnt > 0) mem_cnt--;
        end
        imem_bus.IMem_rsp_valid = mem_busy && (mem_cnt == 0);
        imem_bus.IMem_rsp_data  = (mem_busy && (mem_cnt == 0)) ? ins_of(mem_addr) : 32'h0;
    end

    // ---------------- behavioural model: flags instead of a state machine -------------------
    logic        m_init = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_req_pc = '0;
    logic        m_busy = 1'b0;     // a request is in flight and its data is wanted
    logic        m_held = 1'b0;     // a fetched instruction waits for decode
    logic [31:0] m_held_pc = '0;
    logic [31:0] m_held_ins = '0;
    logic        m_discard = 1'b0;  // a stale response is still to come
    logic [31:0] m_out_pc = '0;
    logic [31:0] m_out_ins = '0;
    logic        m_out_v = 1'b0;
    logic        m_rv;
    logic        m_got;
    logic [31:0] m_got_pc;
    logic [31:0] m_got_ins;

    function automatic logic model_req_valid();
        return !Reset && !Redirect_valid &&
               ((!m_busy && !m_held && !m_discard) ||
                (m_busy && imem_bus.IMem_rsp_valid && !IF_Stall));
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_init    = 1'b1;
            m_pc      = RST_PC;
            m_busy    = 1'b0;
            m_held    = 1'b0;
            m_discard = 1'b0;
            m_out_pc  = '0;
            m_out_ins = NOP;
            m_out_v   = 1'b0;
        end else if (m_init) begin
            m_rv = model_req_valid();
            if (Redirect_valid) begin
                m_discard = (m_busy || m_discard) && !imem_bus.IMem_rsp_valid;
                m_busy    = 1'b0;
                m_held    = 1'b0;
                m_pc      = {Redirect_PC[31:2], 2'b00};
                m_out_pc  = '0;
                m_out_ins = NOP;
                m_out_v   = 1'b0;
            end else begin
                m_got = 1'b0;
                if (m_busy && imem_bus.IMem_rsp_valid) begin
                    m_busy = 1'b0;
                    if (IF_Stall) begin
                        m_held     = 1'b1;
                        m_held_pc  = m_req_pc;
                        m_held_ins = imem_bus.IMem_rsp_data;
                    end else begin
                        m_got     = 1'b1;
                        m_got_pc  = m_req_pc;
                        m_got_ins = imem_bus.IMem_rsp_data;
                    end
                end else if (m_held && !IF_Stall) begin
                    m_got     = 1'b1;
                    m_got_pc  = m_held_pc;
                    m_got_ins = m_held_ins;
                    m_held    = 1'b0;
                end
                if (m_discard && imem_bus.IMem_rsp_valid) m_discard = 1'b0;
                if (m_rv && imem_bus.IMem_req_ready) begin
                    m_busy   = 1'b1;
                    m_req_pc = m_pc;
                    m_pc     = m_pc + 32'd4;
                end
                if (m_got) begin
                    m_out_pc  = m_got_pc;
                    m_out_ins = m_got_ins;
                    m_out_v   = 1'b1;
                end else if (!IF_Stall) begin
                    m_out_pc  = '0;
                    m_out_ins = NOP;
                    m_out_v   = 1'b0;
                end
            end
        end
    end

    // ---------------- compare process and edge snapshot for the memory ----------------------
    always @(negedge Clk) begin
        if (m_init) begin
            check("req_valid", {31'b0, imem_bus.IMem_req_valid}, {31'b0, model_req_valid()});
            check("imem_addr", imem_bus.IMem_addr, m_pc);
            check("if_pc", IF_PC, m_out_pc);
            check("if_instr", IF_Instruction, m_out_ins);
            check("if_valid", {31'b0, IF_Valid}, {31'b0, m_out_v});
        end
        snap_hs    = imem_bus.IMem_req_valid && imem_bus.IMem_req_ready;
        snap_rsp   = imem_bus.IMem_rsp_valid;
        snap_addr  = imem_bus.IMem_addr;
        snap_lat   = mem_lat;
        snap_reset = Reset;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: still running at t=%0t, expected finish earlier", $time);
        $fatal(1);
    end

    // ---------------- directed stimulus with literal expectations ---------------------------
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        Reset                   = 1'b1;
        IF_Stall                = 1'b0;
        Redirect_valid          = 1'b0;
        Redirect_PC             = '0;
        imem_bus.IMem_req_ready = 1'b1;
        mem_lat                 = 1;
        cyc();
        cyc();
        Reset = 1'b0;

        // reset state and back-to-back fetch
        @(negedge Clk);
        lit("rst_if_valid", {31'b0, IF_Valid}, 32'd0);
        lit("rst_if_instr", IF_Instruction, NOP);
        lit("rst_if_pc", IF_PC, 32'h0);
        lit("c1_req_valid", {31'b0, imem_bus.IMem_req_valid}, 32'd1);
        lit("c1_addr", imem_bus.IMem_addr, 32'h100);
        cyc();
        @(negedge Clk);
        lit("c2_addr", imem_bus.IMem_addr, 32'h104);
        lit("c2_if_valid", {31'b0, IF_Valid}, 32'd0);
        cyc();

        // stall for three cycles while the 0x104 response arrives
        IF_Stall = 1'b1;
        @(negedge Clk);
        lit("c3_if_valid", {31'b0, IF_Valid}, 32'd1);
        lit("c3_if_pc", IF_PC, 32'h100);
        lit("c3_if_instr", IF_Instruction, ins_of(32'h100));
        lit("c3_no_req", {31'b0, imem_bus.IMem_req_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge Clk);
            lit("stall_if_pc", IF_PC, 32'h100);
            lit("stall_no_req", {31'b0, imem_bus.IMem_req_valid}, 32'd0);
        end
        cyc();
        IF_Stall = 1'b0;
        @(negedge Clk);
        lit("hold_no_req", {31'b0, imem_bus.IMem_req_valid}, 32'd0);
        cyc();
        @(negedge Clk);
        lit("unhold_if_pc", IF_PC, 32'h104);
        lit("unhold_if_instr", IF_Instruction, ins_of(32'h104));
        lit("resume_addr", imem_bus.IMem_addr, 32'h108);
        cyc();

        // redirect to 0x203 while the 0x10C request is outstanding with 4-cycle latency
        mem_lat = 4;
        @(negedge Clk);
        lit("c8_addr", imem_bus.IMem_addr, 32'h10C);
        cyc();
        Redirect_valid = 1'b1;
        Redirect_PC    = 32'h0000_0203;
        mem_lat        = 1;
        @(negedge Clk);
        lit("c9_if_pc", IF_PC, 32'h108);
        lit("redir_no_req", {31'b0, imem_bus.IMem_req_valid}, 32'd0);
        cyc();
        Redirect_valid = 1'b0;
        @(negedge Clk);
        lit("redir_bubble_v", {31'b0, IF_Valid}, 32'd0);
        lit("redir_bubble_i", IF_Instruction, NOP);
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge Clk);
            lit("drain_no_req", {31'b0, imem_bus.IMem_req_valid}, 32'd0);
        end
        cyc();
        @(negedge Clk);
        lit("stale_dropped", {31'b0, IF_Valid}, 32'd0);
        lit("redir_addr", imem_bus.IMem_addr, 32'h200);
        cyc();
        cyc();
        @(negedge Clk);
        lit("redir_if_pc", IF_PC, 32'h200);
        lit("redir_if_instr", IF_Instruction, ins_of(32'h200));

        // redirect and stall together, target sets up the PC wrap
        IF_Stall       = 1'b1;
        Redirect_valid = 1'b1;
        Redirect_PC    = 32'hFFFF_FFFC;
        @(negedge Clk);
        lit("rs_no_req", {31'b0, imem_bus.IMem_req_valid}, 32'd0);
        cyc();
        IF_Stall       = 1'b0;
        Redirect_valid = 1'b0;
        @(negedge Clk);
        lit("rs_bubble_v", {31'b0, IF_Valid}, 32'd0);
        lit("rs_bubble_i", IF_Instruction, NOP);
        lit("wrap_src_addr", imem_bus.IMem_addr, 32'hFFFF_FFFC);
        cyc();
        @(negedge Clk);
        lit("wrap_addr", imem_bus.IMem_addr, 32'h0);
        cyc();

        // ready low for five cycles in FETCH
        imem_bus.IMem_req_ready = 1'b0;
        @(negedge Clk);
        lit("wrap_if_pc", IF_PC, 32'hFFFF_FFFC);
        cyc();
        @(negedge Clk);
        lit("c19_if_pc", IF_PC, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge Clk);
            lit("nrdy_valid", {31'b0, imem_bus.IMem_req_valid}, 32'd1);
            lit("nrdy_addr", imem_bus.IMem_addr, 32'h4);
            lit("nrdy_if_valid", {31'b0, IF_Valid}, 32'd0);
            lit("nrdy_if_instr", IF_Instruction, NOP);
        end
        cyc();
        imem_bus.IMem_req_ready = 1'b1;
        cyc();
        @(negedge Clk);
        lit("rdy_addr", imem_bus.IMem_addr, 32'h8);
        cyc();
        mem_lat = 4;
        @(negedge Clk);
        lit("rdy_if_pc", IF_PC, 32'h4);
        cyc();

        // reset with a request in flight
        Reset = 1'b1;
        @(negedge Clk);
        lit("rst_no_req", {31'b0, imem_bus.IMem_req_valid}, 32'd0);
        cyc();
        Reset   = 1'b0;
        mem_lat = 1;
        @(negedge Clk);
        lit("rerst_addr", imem_bus.IMem_addr, RST_PC);
        lit("rerst_if_valid", {31'b0, IF_Valid}, 32'd0);

        // mixed stall / ready / latency / redirect pattern, checked by the model
        for (int i = 0; i < 60; i++) begin
            cyc();
            IF_Stall                = (i % 5 == 3) || (i % 11 == 7);
            imem_bus.IMem_req_ready = (i % 7) != 2;
            mem_lat                 = 1 + (i % 3);
            Redirect_valid          = (i == 25) || (i == 41);
            Redirect_PC             = (i == 25) ? 32'h0000_0402 : 32'h0000_0300;
        end
        cyc();
        IF_Stall                = 1'b0;
        Redirect_valid          = 1'b0;
        imem_bus.IMem_req_ready = 1'b1;
        repeat (6) cyc();
        @(negedge Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
